mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum cycles a granted access waits for mem_ack_i.
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  asynchronous reset, active-high.
REQ-006 start_i  in  1  enables new grants; 0 blocks new grants but lets an in-flight access finish.
REQ-007 if_req_i  in  1  / if_addr_i  in  ADDR_W: instruction-fetch read request and address; held until if_ready_o.
REQ-008 if_rdata_o  out  DATA_W  / if_ready_o  out  1: fetch read data and one-cycle completion pulse.
REQ-009 dm_req_i  in  1  / dm_we_i  in  1  / dm_addr_i  in  ADDR_W  / dm_wdata_i  in  DATA_W: data-stage request (MemRead|MemWrite), write enable, address, write data; held until dm_ready_o.
REQ-010 dm_rdata_o  out  DATA_W  / dm_ready_o  out  1: data read result and one-cycle completion pulse.
REQ-011 mem_req_o  out  1  / mem_we_o  out  1  / mem_addr_o  out  ADDR_W  / mem_wdata_o  out  DATA_W: registered shared-memory request.
REQ-012 mem_ack_i  in  1  / mem_rdata_i  in  DATA_W: one-cycle memory acknowledge and read data valid with it.
REQ-013 stall_o  out  1  pipeline freeze for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
REQ-014 err_o  out  1  sticky timeout flag.

Function
REQ-015 FSM states IDLE, BUSY_D, BUSY_I, DONE.
REQ-016 IDLE and start_i=1: dm_req_i alone -> BUSY_D; if_req_i alone -> BUSY_I; both -> requester not in last_grant; none -> stay IDLE.
REQ-017 last_grant: 1-bit register, updated on every grant; reset value = I, so data wins the first conflict.
REQ-018 On the grant edge, mem_req_o=1 and mem_addr_o/mem_we_o/mem_wdata_o are latched from the winner; if_req grants force mem_we_o=0.
REQ-019 In BUSY_x, mem_req_o and mem_* stay stable until the cycle mem_ack_i=1 is sampled.
REQ-020 On ack edge: mem_req_o->0, mem_rdata_i captured into the winner's rdata register (reads only), state->DONE.
REQ-021 DONE: winner's ready_o=1 for exactly this cycle, then IDLE; no grant issued from DONE.
REQ-022 Latency: request sampled in IDLE at edge N, mem_req_o high from N, ack sampled at edge M, ready_o high during cycle M..M+1, next grant no earlier than edge M+2.
REQ-023 if_rdata_o/dm_rdata_o hold their value until overwritten by the next completed read for that requester; writes leave dm_rdata_o unchanged.
REQ-024 stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o), combinational.
REQ-025 Wait counter: cleared on grant, +1 per BUSY cycle without ack; width ceil(log2(TIMEOUT_CYC+1)), no wrap.
REQ-026 Counter reaching TIMEOUT_CYC: err_o=1 (sticky until reset), mem_req_o->0, winner's rdata register loaded with 0, state->DONE.
REQ-027 mem_ack_i and timeout on the same edge: ack wins, err_o unchanged.
REQ-028 mem_ack_i in IDLE or DONE: ignored, no state or data change.
REQ-029 start_i falling during BUSY_x: access completes normally; start_i=0 in IDLE: no grant, stall_o still follows REQ-024.

Reset
REQ-030 rst_i=1 asynchronously: state=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, if/dm rdata=0, ready outputs=0, err_o=0, counter=0, last_grant=I.
REQ-031 Reset during BUSY_x abandons the access; a later mem_ack_i is ignored per REQ-028.

Structure
REQ-032 State encoding enum, grant-id constants (GNT_I, GNT_D) and default parameter values live in shared package cpu_pkg.
REQ-033 Wait counter with timeout compare is one sub-module, arb_timer; the rest is flat.

Verification
REQ-034 dm_req_i=1, dm_we_i=0, addr 0x40; ack after 3 cycles with 0xDEADBEEF -> mem_addr_o=0x40 for 3 cycles, dm_ready_o one pulse, dm_rdata_o=0xDEADBEEF, stall_o high until that pulse.
REQ-035 if_req_i and dm_req_i both high from reset, immediate acks -> D served first, then I; repeat twice more -> grants alternate D,I,D,I.
REQ-036 Data write addr 0x80 data 0x12345678 -> mem_we_o=1, mem_wdata_o=0x12345678; dm_rdata_o keeps its prior value.
REQ-037 TIMEOUT_CYC=4, no ack -> mem_req_o drops after 4 BUSY cycles, err_o=1 and stays set, ready pulse with rdata 0.
REQ-038 rst_i asserted mid-BUSY_I, ack arrives 2 cycles after release -> all outputs at reset values, no ready pulse.
REQ-039 start_i=0 with if_req_i=1 for 10 cycles -> mem_req_o stays 0, stall_o=1; start_i->1 -> grant on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, grant ids and default sizes.
package cpu_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/arb_timer.sv
// Access wait counter: cleared on grant, counts busy cycles without ack, saturates at TIMEOUT_CYC.
module arb_timer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int            CW   = cnt_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYC);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // High when the coming un-acked edge brings the count up to TIMEOUT_CYC.
  assign expire_o = (r_cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single shared memory port with alternating priority.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  arb_state_e        r_state;
  logic              r_last_grant;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_err;

  logic w_busy;
  logic w_grant;
  logic w_pick_d;
  logic w_expire;

  assign w_busy   = (r_state == BUSY_D) || (r_state == BUSY_I);
  assign w_grant  = (r_state == IDLE) && start_i && (if_req_i || dm_req_i);
  // On a conflict the requester that did not win last time is served.
  assign w_pick_d = dm_req_i && (!if_req_i || (r_last_grant == GNT_I));

  arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (w_grant),
    .inc_i   (w_busy && !mem_ack_i),
    .expire_o(w_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_I;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_mem_req <= 1'b1;
            if (w_pick_d) begin
              r_state      <= BUSY_D;
              r_last_grant <= GNT_D;
              r_mem_we     <= dm_we_i;
              r_mem_addr   <= dm_addr_i;
              r_mem_wdata  <= dm_wdata_i;
            end else begin
              r_state      <= BUSY_I;
              r_last_grant <= GNT_I;
              r_mem_we     <= 1'b0;
              r_mem_addr   <= if_addr_i;
            end
          end
        end
        BUSY_D, BUSY_I: begin
          // Ack takes precedence over a timeout landing on the same edge.
          if (mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_state   <= DONE;
            if (r_state == BUSY_I) begin
              r_if_rdata <= mem_rdata_i;
            end else if (!r_mem_we) begin
              r_dm_rdata <= mem_rdata_i;
            end
          end else if (w_expire) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= DONE;
            if (r_state == BUSY_I) begin
              r_if_rdata <= '0;
            end else begin
              r_dm_rdata <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_ready_o  = (r_state == DONE) && (r_last_grant == GNT_I);
  assign dm_ready_o  = (r_state == DONE) && (r_last_grant == GNT_D);
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign err_o       = r_err;
  assign stall_o     = (if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter, built with a short timeout so the expiry path is reachable.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b1;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic [DW-1:0] if_rdata_o;
  logic          if_ready_o;
  logic          dm_req_i = 1'b0;
  logic          dm_we_i = 1'b0;
  logic [AW-1:0] dm_addr_i = '0;
  logic [DW-1:0] dm_wdata_i = '0;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_ready_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          stall_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_dm_rdata;
  logic [DW-1:0] exp_if_rdata;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, mem_we_o, if_ready_o, dm_ready_o, err_o, stall_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {mem_req_o, mem_we_o, if_ready_o, dm_ready_o, err_o, stall_o});
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o} !== 64'h0) begin
      errors++;
      $display("FAIL reset_mem: addr %h wdata %h want 0", mem_addr_o, mem_wdata_o);
    end
    checks++;
    if ({if_rdata_o, dm_rdata_o} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: if %h dm %h want 0", if_rdata_o, dm_rdata_o);
    end
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_read_single();
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL rd_stall_pre: got %b want 1", stall_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40 || stall_o !== 1'b1) begin
        errors++;
        $display("FAIL rd_busy%0d: req %b addr %h stall %b want 1 00000040 1", i, mem_req_o, mem_addr_o, stall_o);
      end
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    step();
    mem_ack_i = 1'b0;
    checks++;
    if (dm_ready_o !== 1'b1 || dm_rdata_o !== 32'hDEADBEEF || mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: ready %b rdata %h req %b stall %b want 1 deadbeef 0 0",
               dm_ready_o, dm_rdata_o, mem_req_o, stall_o);
    end
    dm_req_i = 1'b0;
    step();
    checks++;
    if (dm_ready_o !== 1'b0 || dm_rdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_after: ready %b rdata %h want 0 deadbeef", dm_ready_o, dm_rdata_o);
    end
  endtask

  task automatic test_alternate();
    logic exp_d;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_d = ((k % 2) == 0);
      step();
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== (exp_d ? 32'h200 : 32'h100)) begin
        errors++;
        $display("FAIL alt_grant%0d: req %b addr %h want 1 %h", k, mem_req_o, mem_addr_o,
                 exp_d ? 32'h200 : 32'h100);
      end
      mem_rdata_i = 32'hA000_0000 + k;
      mem_ack_i = 1'b1;
      if (exp_d) exp_dm_rdata = 32'hA000_0000 + k;
      else       exp_if_rdata = 32'hA000_0000 + k;
      step();
      mem_ack_i = 1'b0;
      checks++;
      if (dm_ready_o !== exp_d || if_ready_o !== !exp_d ||
          dm_rdata_o !== exp_dm_rdata || if_rdata_o !== exp_if_rdata) begin
        errors++;
        $display("FAIL alt_done%0d: dm_rdy %b if_rdy %b dm %h if %h want %b %b %h %h", k,
                 dm_ready_o, if_ready_o, dm_rdata_o, if_rdata_o, exp_d, !exp_d, exp_dm_rdata, exp_if_rdata);
      end
      step();
      checks++;
      if (mem_req_o !== 1'b0 || dm_ready_o !== 1'b0 || if_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL alt_idle%0d: req %b dm_rdy %b if_rdy %b want 0 0 0", k, mem_req_o, dm_ready_o, if_ready_o);
      end
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    step();
  endtask

  task automatic test_write();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h80; dm_wdata_i = 32'h12345678;
    step();
    checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h80 || mem_wdata_o !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_grant: req %b we %b addr %h wdata %h want 1 1 00000080 12345678",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    step();
    mem_ack_i = 1'b0;
    checks++;
    if (dm_ready_o !== 1'b1 || dm_rdata_o !== exp_dm_rdata) begin
      errors++;
      $display("FAIL wr_done: ready %b rdata %h want 1 %h", dm_ready_o, dm_rdata_o, exp_dm_rdata);
    end
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    step();
  endtask

  task automatic test_ack_at_limit();
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h44;
    step();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (mem_req_o !== 1'b1 || err_o !== 1'b0) begin
      errors++; $display("FAIL lim_busy: req %b err %b want 1 0", mem_req_o, err_o);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    step();
    mem_ack_i = 1'b0;
    exp_dm_rdata = 32'hCAFEF00D;
    checks++;
    if (dm_ready_o !== 1'b1 || err_o !== 1'b0 || dm_rdata_o !== exp_dm_rdata) begin
      errors++;
      $display("FAIL lim_ack: ready %b err %b rdata %h want 1 0 cafef00d", dm_ready_o, err_o, dm_rdata_o);
    end
    dm_req_i = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    if_req_i = 1'b1; if_addr_i = 32'h300;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (mem_req_o !== 1'b1 || err_o !== 1'b0) begin
        errors++; $display("FAIL to_busy%0d: req %b err %b want 1 0", i, mem_req_o, err_o);
      end
    end
    step();
    checks++;
    if (mem_req_o !== 1'b0 || err_o !== 1'b1 || if_ready_o !== 1'b1 || if_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL to_expire: req %b err %b ready %b rdata %h want 0 1 1 0",
               mem_req_o, err_o, if_ready_o, if_rdata_o);
    end
    if_req_i = 1'b0;
    step();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11112222;
    step();
    mem_ack_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || if_ready_o !== 1'b0 || mem_req_o !== 1'b0 || if_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL to_sticky: err %b ready %b req %b rdata %h want 1 0 0 0",
               err_o, if_ready_o, mem_req_o, if_rdata_o);
    end
  endtask

  task automatic test_reset_mid_busy();
    if_req_i = 1'b1; if_addr_i = 32'h500;
    step();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h500) begin
      errors++; $display("FAIL rmb_grant: req %b addr %h want 1 00000500", mem_req_o, mem_addr_o);
    end
    rst_i = 1'b1;
    #1;
    if_req_i = 1'b0;
    checks++;
    if ({mem_req_o, mem_we_o, if_ready_o, dm_ready_o, err_o} !== 5'b0 || mem_addr_o !== 32'h0 ||
        dm_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rmb_async: req %b we %b rdy %b %b err %b addr %h dm %h want all 0",
               mem_req_o, mem_we_o, if_ready_o, dm_ready_o, err_o, mem_addr_o, dm_rdata_o);
    end
    step();
    rst_i = 1'b0;
    step();
    step();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
    step();
    mem_ack_i = 1'b0;
    checks++;
    if (if_ready_o !== 1'b0 || dm_ready_o !== 1'b0 || mem_req_o !== 1'b0 || if_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rmb_late_ack: if_rdy %b dm_rdy %b req %b rdata %h want 0 0 0 0",
               if_ready_o, dm_ready_o, mem_req_o, if_rdata_o);
    end
  endtask

  task automatic test_start_gate();
    int bad;
    bad = 0;
    start_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h600;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_req_o !== 1'b0 || stall_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL sg_blocked: %0d bad cycles want 0 (req %b stall %b)", bad, mem_req_o, stall_o);
    end
    start_i = 1'b1;
    step();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h600 || mem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL sg_grant: req %b addr %h we %b want 1 00000600 0", mem_req_o, mem_addr_o, mem_we_o);
    end
    start_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBEEF0600;
    step();
    mem_ack_i = 1'b0;
    checks++;
    if (if_ready_o !== 1'b1 || if_rdata_o !== 32'hBEEF0600) begin
      errors++; $display("FAIL sg_finish: ready %b rdata %h want 1 beef0600", if_ready_o, if_rdata_o);
    end
    if_req_i = 1'b0;
    start_i = 1'b1;
    step();
  endtask

  initial begin
    exp_dm_rdata = '0;
    exp_if_rdata = '0;
    test_reset();
    test_read_single();
    test_alternate();
    test_write();
    test_ack_at_limit();
    test_timeout();
    test_reset_mid_busy();
    test_start_gate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
